// File: rtl/ds_operand_bypass.sv
// Decode-stage operand unit: fs->ds pipeline register, handshake, rs/rt forwarding and interlock.
// Optional `DS_STALL_CNT_EN adds a saturating stall-cycle counter output (stall_cnt).
module ds_operand_bypass #(
    parameter int FW_STAGES = 3,
    parameter int DATA_W    = 32,
    parameter int REG_AW    = 5
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    in_valid,
    output logic                                    in_allowin,
    input  logic [31:0]                             in_pc,
    input  logic [31:0]                             in_inst,
    input  logic                                    flush,
    output logic                                    out_valid,
    input  logic                                    out_allowin,
    output logic [31:0]                             out_pc,
    output logic [31:0]                             out_inst,
    output logic [REG_AW-1:0]                       rf_raddr1,
    output logic [REG_AW-1:0]                       rf_raddr2,
    input  logic [DATA_W-1:0]                       rf_rdata1,
    input  logic [DATA_W-1:0]                       rf_rdata2,
    input  logic [FW_STAGES*(2+REG_AW+DATA_W)-1:0]  fw_bus,
    output logic [DATA_W-1:0]                       rs_value,
    output logic [DATA_W-1:0]                       rt_value,
`ifdef DS_STALL_CNT_EN
    output logic [31:0]                             stall_cnt,
`endif
    output logic                                    stall
);
    localparam int SW = 2 + REG_AW + DATA_W;

    logic                               r_ds_valid;
    logic [31:0]                        r_pc;
    logic [31:0]                        r_inst;
    logic [FW_STAGES-1:0]               w_rdy;
    logic [FW_STAGES-1:0]               w_vld;
    logic [FW_STAGES-1:0][REG_AW-1:0]   w_dest;
    logic [FW_STAGES-1:0][DATA_W-1:0]   w_data;
    logic                               w_rs_hz;
    logic                               w_rt_hz;
    logic                               w_ready_go;

    // Per-source layout {ready,valid,dest,data}, source 0 in the LSBs.
    genvar g;
    generate
        for (g = 0; g < FW_STAGES; g++) begin : g_unpack
            assign w_data[g] = fw_bus[g*SW +: DATA_W];
            assign w_dest[g] = fw_bus[g*SW + DATA_W +: REG_AW];
            assign w_vld[g]  = fw_bus[g*SW + DATA_W + REG_AW];
            assign w_rdy[g]  = fw_bus[g*SW + DATA_W + REG_AW + 1];
        end
    endgenerate

    assign rf_raddr1 = r_inst[21 +: REG_AW];
    assign rf_raddr2 = r_inst[16 +: REG_AW];

    // Scan oldest to youngest so the youngest matching producer overrides.
    always_comb begin
        rs_value = rf_rdata1;
        rt_value = rf_rdata2;
        w_rs_hz  = 1'b0;
        w_rt_hz  = 1'b0;
        for (int i = FW_STAGES - 1; i >= 0; i--) begin
            if (w_vld[i] && (w_dest[i] == rf_raddr1) && (rf_raddr1 != '0)) begin
                rs_value = w_data[i];
                w_rs_hz  = !w_rdy[i];
            end
            if (w_vld[i] && (w_dest[i] == rf_raddr2) && (rf_raddr2 != '0)) begin
                rt_value = w_data[i];
                w_rt_hz  = !w_rdy[i];
            end
        end
    end

    assign w_ready_go = !(w_rs_hz || w_rt_hz);
    assign in_allowin = !r_ds_valid || (w_ready_go && out_allowin);
    assign out_valid  = r_ds_valid && w_ready_go;
    assign stall      = r_ds_valid && !w_ready_go;
    assign out_pc     = r_pc;
    assign out_inst   = r_inst;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ds_valid <= 1'b0;
            r_pc       <= '0;
            r_inst     <= '0;
        end else begin
            if (flush)
                r_ds_valid <= 1'b0;
            else if (in_allowin)
                r_ds_valid <= in_valid;
            if (in_valid && in_allowin) begin
                r_pc   <= in_pc;
                r_inst <= in_inst;
            end
        end
    end

`ifdef DS_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (reset)
            r_stall_cnt <= '0;
        else if (stall && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + 32'd1;
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_ds_operand_bypass.sv
// Bench for ds_operand_bypass: directed sequences, a vector table, and random traffic vs a reference model.
module tb_ds_operand_bypass;
    typedef struct packed {
        logic        ready;
        logic        valid;
        logic [4:0]  dest;
        logic [31:0] data;
    } src_t;

    typedef struct {
        logic [4:0]  rs, rt;
        src_t        s0, s1, s2;
        logic [31:0] rf1, rf2, ers, ert;
        logic        estall;
    } vec_t;

    logic        clk = 0, reset = 1;
    logic        in_valid = 0, in_allowin, flush = 0, out_valid, out_allowin = 0, stall;
    logic [31:0] in_pc = 0, in_inst = 0, out_pc, out_inst;
    logic [4:0]  rf_raddr1, rf_raddr2;
    logic [31:0] rf_rdata1 = 0, rf_rdata2 = 0, rs_value, rt_value;
    src_t        srcs[3];
    logic [116:0] fw_bus;
`ifdef DS_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int n_chk = 0, n_fail = 0;

    assign fw_bus = {srcs[2], srcs[1], srcs[0]};
    always #5 clk = ~clk;

    ds_operand_bypass dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_allowin(in_allowin),
        .in_pc(in_pc), .in_inst(in_inst), .flush(flush), .out_valid(out_valid),
        .out_allowin(out_allowin), .out_pc(out_pc), .out_inst(out_inst),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1),
        .rf_rdata2(rf_rdata2), .fw_bus(fw_bus), .rs_value(rs_value), .rt_value(rt_value),
`ifdef DS_STALL_CNT_EN
        .stall_cnt(stall_cnt),
`endif
        .stall(stall)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt);
        return {6'd0, rs, rt, 5'd3, 5'd0, 6'h21};
    endfunction

    // Reference: first (youngest) matching source decides; $0 never matches.
    function automatic void ref_op(input logic [4:0] r, input logic [31:0] rf,
                                   output logic [31:0] v, output logic hz);
        v = rf; hz = 1'b0;
        if (r != 5'd0)
            for (int i = 0; i < 3; i++)
                if (srcs[i].valid && srcs[i].dest == r) begin
                    v = srcs[i].data; hz = !srcs[i].ready; break;
                end
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clr_srcs();
        for (int i = 0; i < 3; i++) srcs[i] = '0;
    endtask

    task automatic do_reset();
        reset = 1; in_valid = 0; flush = 0; clr_srcs();
        tick(); tick();
        reset = 0;
    endtask

    task automatic capture(input logic [31:0] pc, input logic [31:0] inst);
        in_valid = 1; in_pc = pc; in_inst = inst;
        tick();
        in_valid = 0;
    endtask

    vec_t vt[7];
    logic        m_valid, hz1, hz2, e_stall, e_go, e_allow;
    logic [31:0] m_pc, m_inst, e_rs, e_rt, m_cnt;

    initial begin
        clr_srcs();
        vt[0] = '{5'd1, 5'd2, '0, '0, '0, 32'd5, 32'd7, 32'd5, 32'd7, 1'b0};
        vt[1] = '{5'd1, 5'd2, '{1'b1, 1'b1, 5'd1, 32'hAA}, '0, '{1'b1, 1'b1, 5'd1, 32'hBB},
                  32'd5, 32'd7, 32'hAA, 32'd7, 1'b0};
        vt[2] = '{5'd1, 5'd2, '{1'b0, 1'b1, 5'd2, 32'h11}, '0, '{1'b1, 1'b1, 5'd2, 32'hCC},
                  32'd5, 32'd7, 32'd5, 32'h11, 1'b1};
        vt[3] = '{5'd0, 5'd0, '{1'b0, 1'b1, 5'd0, 32'h55}, '0, '0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0};
        vt[4] = '{5'd3, 5'd3, '0, '{1'b1, 1'b1, 5'd3, 32'h33}, '{1'b0, 1'b1, 5'd3, 32'h44},
                  32'd1, 32'd2, 32'h33, 32'h33, 1'b0};
        vt[5] = '{5'd4, 5'd5, '{1'b0, 1'b0, 5'd4, 32'h9}, '0, '{1'b1, 1'b1, 5'd5, 32'h77},
                  32'd8, 32'd9, 32'd8, 32'h77, 1'b0};
        vt[6] = '{5'd6, 5'd7, '0, '{1'b0, 1'b1, 5'd6, 32'h66}, '0,
                  32'd1, 32'd2, 32'h66, 32'd2, 1'b1};

        // Reset state
        do_reset();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_stall", stall, 0);
        chk("rst_in_allowin", in_allowin, 1);
        chk("rst_out_pc", out_pc, 0);
`ifdef DS_STALL_CNT_EN
        chk("rst_stall_cnt", stall_cnt, 0);
`endif

        // Flush while stalled, with three stall cycles counted
        out_allowin = 1;
        capture(32'h100, mk(5'd1, 5'd2));
        srcs[0] = '{1'b0, 1'b1, 5'd1, 32'h0};
        #1 chk("fl_stall_a", stall, 1);
        tick(); chk("fl_stall_b", stall, 1);
        tick(); chk("fl_stall_c", stall, 1);
        flush = 1;
        tick(); flush = 0;
        chk("fl_out_valid", out_valid, 0);
        chk("fl_in_allowin", in_allowin, 1);
        chk("fl_stall_clr", stall, 0);
`ifdef DS_STALL_CNT_EN
        chk("fl_stall_cnt", stall_cnt, 3);
`endif
        clr_srcs();

        // Basic capture: addu $3,$1,$2
        rf_rdata1 = 5; rf_rdata2 = 7;
        chk("cap_pre_valid", out_valid, 0);
        capture(32'hBFC00000, mk(5'd1, 5'd2));
        chk("cap_out_valid", out_valid, 1);
        chk("cap_out_pc", out_pc, 32'hBFC00000);
        chk("cap_raddr1", rf_raddr1, 1);
        chk("cap_raddr2", rf_raddr2, 2);
        chk("cap_rs", rs_value, 5);
        chk("cap_rt", rt_value, 7);

        // Load-use interlock, then an older ready producer resolves it
        capture(32'hBFC00004, mk(5'd1, 5'd2));
        srcs[0] = '{1'b0, 1'b1, 5'd2, 32'hDEAD};
        in_valid = 1; in_pc = 32'hBFC00008; in_inst = mk(5'd9, 5'd9);
        #1;
        chk("lu_stall", stall, 1);
        chk("lu_out_valid", out_valid, 0);
        chk("lu_in_allowin", in_allowin, 0);
        tick();
        chk("lu_pc_held", out_pc, 32'hBFC00004);
        srcs[0] = '0; srcs[1] = '{1'b1, 1'b1, 5'd2, 32'h1234};
        #1;
        chk("lu_rt_fwd", rt_value, 32'h1234);
        chk("lu_out_valid2", out_valid, 1);
        chk("lu_in_allowin2", in_allowin, 1);
        tick(); in_valid = 0;
        chk("lu_next_pc", out_pc, 32'hBFC00008);
        clr_srcs();

        // Vector table: hold one instruction per vector with es blocked
        out_allowin = 0;
        for (int k = 0; k < 7; k++) begin
            clr_srcs();
            flush = 1; tick(); flush = 0;
            capture(32'h2000 + k * 4, mk(vt[k].rs, vt[k].rt));
            srcs[0] = vt[k].s0; srcs[1] = vt[k].s1; srcs[2] = vt[k].s2;
            rf_rdata1 = vt[k].rf1; rf_rdata2 = vt[k].rf2;
            #1;
            chk($sformatf("vec%0d_rs", k), rs_value, vt[k].ers);
            chk($sformatf("vec%0d_rt", k), rt_value, vt[k].ert);
            chk($sformatf("vec%0d_stall", k), stall, vt[k].estall);
            chk($sformatf("vec%0d_out_valid", k), out_valid, !vt[k].estall);
            chk($sformatf("vec%0d_in_allowin", k), in_allowin, 0);
            tick();
        end

        // Random traffic against the reference model
        do_reset();
        m_valid = 0; m_pc = 0; m_inst = 0; m_cnt = 0;
        for (int c = 0; c < 600; c++) begin
            in_valid = $urandom_range(0, 1);
            in_pc = $urandom;
            in_inst = $urandom;
            in_inst[25:21] = 5'($urandom_range(0, 3));
            in_inst[20:16] = 5'($urandom_range(0, 3));
            flush = ($urandom_range(0, 15) == 0);
            out_allowin = $urandom_range(0, 1);
            rf_rdata1 = $urandom; rf_rdata2 = $urandom;
            for (int i = 0; i < 3; i++)
                srcs[i] = '{1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                            5'($urandom_range(0, 3)), $urandom};
            #1;
            ref_op(m_inst[25:21], rf_rdata1, e_rs, hz1);
            ref_op(m_inst[20:16], rf_rdata2, e_rt, hz2);
            e_go = !(hz1 || hz2);
            e_stall = m_valid && !e_go;
            e_allow = !m_valid || (e_go && out_allowin);
            chk("rnd_rs", rs_value, e_rs);
            chk("rnd_rt", rt_value, e_rt);
            chk("rnd_stall", stall, e_stall);
            chk("rnd_out_valid", out_valid, m_valid && e_go);
            chk("rnd_in_allowin", in_allowin, e_allow);
            chk("rnd_out_pc", out_pc, m_pc);
            chk("rnd_out_inst", out_inst, m_inst);
            if (e_stall && m_cnt != 32'hFFFFFFFF) m_cnt++;
            if (in_valid && e_allow) begin m_pc = in_pc; m_inst = in_inst; end
            if (flush) m_valid = 0;
            else if (e_allow) m_valid = in_valid;
            tick();
        end
`ifdef DS_STALL_CNT_EN
        chk("rnd_stall_cnt", stall_cnt, m_cnt);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
